// File: rtl/rv32_types.sv
// rtl/rv32_types.sv - RV32 decode types, opcodes and the nop control bundle
package rv32_types;

    typedef logic [31:0] rv_instr_t;

    localparam logic [6:0] OPCODE_LUI         = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC       = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL         = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR        = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH      = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD        = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE       = 7'b0100011;
    localparam logic [6:0] OPCODE_INTEGER_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_INTEGER_REG = 7'b0110011;
    localparam logic [6:0] OPCODE_MISC_MEM    = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM      = 7'b1110011;

    typedef enum logic [1:0] {UNIT_ALU = 2'd0, UNIT_MULDIV = 2'd1, UNIT_CSR = 2'd2} exec_unit_t;

    // Encoding is {funct7[5], funct3} so R/I-type fields map straight across
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000, ALU_SRA = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {ALU_SRC1_RS1 = 2'd0, ALU_SRC1_PC = 2'd1, ALU_SRC1_ZERO = 2'd2} alu_src1_t;

    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_CSR = 2'd3} wb_src_t;

    typedef enum logic [2:0] {
        MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
        MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7
    } muldiv_op_t;

    typedef enum logic [2:0] {
        CSR_NONE = 3'd0, CSR_RW = 3'd1, CSR_RS = 3'd2, CSR_RC = 3'd3,
        CSR_RWI = 3'd5, CSR_RSI = 3'd6, CSR_RCI = 3'd7
    } csr_op_t;

    typedef enum logic [1:0] {SYS_NONE = 2'd0, SYS_ECALL = 2'd1, SYS_EBREAK = 2'd2} sys_op_t;

    // {is_store, funct3}; 4'b1111 is never a real access so it marks "no access"
    typedef logic [3:0] mem_op_t;
    localparam mem_op_t MEM_NOP = 4'b1111;

    typedef struct packed {
        logic       invalid;
        logic       register_wb;
        exec_unit_t unit;
        alu_op_t    alu_op;
        alu_src1_t  alu_src1;
        logic       alu_src2_imm;
        mem_op_t    mem_op;
        wb_src_t    wb_result_src;
        logic       is_branch;
        logic       is_jump;
        muldiv_op_t muldiv_op;
        csr_op_t    csr_op;
        sys_op_t    sys_op;
    } decoded_instr_t;

    function automatic decoded_instr_t create_nop_ctrl();
        decoded_instr_t c;
        c.invalid       = 1'b0;
        c.register_wb   = 1'b0;
        c.unit          = UNIT_ALU;
        c.alu_op        = ALU_ADD;
        c.alu_src1      = ALU_SRC1_RS1;
        c.alu_src2_imm  = 1'b0;
        c.mem_op        = MEM_NOP;
        c.wb_result_src = WB_ALU;
        c.is_branch     = 1'b0;
        c.is_jump       = 1'b0;
        c.muldiv_op     = MD_MUL;
        c.csr_op        = CSR_NONE;
        c.sys_op        = SYS_NONE;
        return c;
    endfunction

endpackage

// File: rtl/rv32_decode_buffer_if.sv
// rtl/rv32_decode_buffer_if.sv - fetch-side and issue-side handshakes of the decode buffer
interface rv32_decode_buffer_if;
    import rv32_types::*;

    logic           in_valid;
    logic           in_ready;
    rv_instr_t      in_instr;
    logic [31:0]    in_pc;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_pc;
    rv_instr_t      out_instr;
    decoded_instr_t out_decoded;
    logic [1:0]     out_use_rs;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_decoded, out_use_rs
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_decoded, out_use_rs
    );
endinterface

// File: rtl/rv32_decoder_ext.sv
// rtl/rv32_decoder_ext.sv - combinational RV32I + M + Zicsr decoder with funct7 legality
module rv32_decoder_ext
    import rv32_types::*;
#(
    parameter bit ENABLE_M     = 1'b1,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  rv_instr_t      instr,
    output decoded_instr_t decoded,
    output logic [1:0]     use_rs
);

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [4:0]     rd;
    logic           illegal;
    decoded_instr_t dec;
    logic [1:0]     rs;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    always_comb begin
        dec     = create_nop_ctrl();
        rs      = 2'b00;
        illegal = 1'b0;
        case (opcode)
            OPCODE_LUI: begin
                dec.register_wb  = 1'b1;
                dec.alu_src1     = ALU_SRC1_ZERO;
                dec.alu_src2_imm = 1'b1;
            end
            OPCODE_AUIPC: begin
                dec.register_wb  = 1'b1;
                dec.alu_src1     = ALU_SRC1_PC;
                dec.alu_src2_imm = 1'b1;
            end
            OPCODE_JAL: begin
                dec.register_wb   = 1'b1;
                dec.is_jump       = 1'b1;
                dec.alu_src1      = ALU_SRC1_PC;
                dec.alu_src2_imm  = 1'b1;
                dec.wb_result_src = WB_PC4;
            end
            OPCODE_JALR: begin
                illegal           = (funct3 != 3'b000);
                dec.register_wb   = 1'b1;
                dec.is_jump       = 1'b1;
                dec.alu_src2_imm  = 1'b1;
                dec.wb_result_src = WB_PC4;
                rs                = 2'b01;
            end
            OPCODE_BRANCH: begin
                illegal       = (funct3 == 3'b010) || (funct3 == 3'b011);
                dec.is_branch = 1'b1;
                dec.alu_op    = ALU_SUB;
                rs            = 2'b11;
            end
            OPCODE_LOAD: begin
                illegal           = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                dec.register_wb   = 1'b1;
                dec.alu_src2_imm  = 1'b1;
                dec.mem_op        = {1'b0, funct3};
                dec.wb_result_src = WB_MEM;
                rs                = 2'b01;
            end
            OPCODE_STORE: begin
                illegal          = (funct3 > 3'b010);
                dec.alu_src2_imm = 1'b1;
                dec.mem_op       = {1'b1, funct3};
                rs               = 2'b11;
            end
            OPCODE_INTEGER_IMM: begin
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
                dec.register_wb  = 1'b1;
                dec.alu_src2_imm = 1'b1;
                dec.alu_op       = alu_op_t'({(funct3 == 3'b101) && funct7[5], funct3});
                rs               = 2'b01;
            end
            OPCODE_INTEGER_REG: begin
                dec.register_wb = 1'b1;
                rs              = 2'b11;
                case (funct7)
                    7'b0000000: dec.alu_op = alu_op_t'({1'b0, funct3});
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
                        else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
                        else                       illegal    = 1'b1;
                    end
                    7'b0000001: begin
                        if (ENABLE_M) begin
                            dec.unit      = UNIT_MULDIV;
                            dec.muldiv_op = muldiv_op_t'(funct3);
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_MISC_MEM: ;
            OPCODE_SYSTEM: begin
                case (funct3)
                    3'b000: begin
                        // Only the exact ECALL/EBREAK encodings; other privileged forms trap
                        if (instr[19:7] != '0)              illegal    = 1'b1;
                        else if (instr[31:20] == 12'h000)   dec.sys_op = SYS_ECALL;
                        else if (instr[31:20] == 12'h001)   dec.sys_op = SYS_EBREAK;
                        else                                illegal    = 1'b1;
                    end
                    3'b100: illegal = 1'b1;
                    default: begin
                        if (ENABLE_ZICSR) begin
                            dec.unit          = UNIT_CSR;
                            dec.csr_op        = csr_op_t'(funct3);
                            dec.register_wb   = 1'b1;
                            dec.wb_result_src = WB_CSR;
                            rs                = funct3[2] ? 2'b00 : 2'b01;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            dec         = create_nop_ctrl();
            dec.invalid = 1'b1;
            rs          = 2'b00;
        end
        if (rd == 5'd0) begin
            dec.register_wb = 1'b0;
        end
        decoded = dec;
        use_rs  = rs;
    end

endmodule

// File: rtl/rv32_decode_buffer.sv
// rtl/rv32_decode_buffer.sv - instruction buffer with head decode and registered valid/ready output
module rv32_decode_buffer
    import rv32_types::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter bit          ENABLE_M     = 1'b1,
    parameter bit          ENABLE_ZICSR = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    rv32_decode_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    rv_instr_t      instr_mem_q [DEPTH];
    rv_instr_t      instr_mem_d [DEPTH];
    logic [31:0]    pc_mem_q    [DEPTH];
    logic [31:0]    pc_mem_d    [DEPTH];

    logic           out_valid_q, out_valid_d;
    logic [31:0]    out_pc_q, out_pc_d;
    rv_instr_t      out_instr_q, out_instr_d;
    decoded_instr_t out_decoded_q, out_decoded_d;
    logic [1:0]     out_use_rs_q, out_use_rs_d;

    logic           full, empty, push, pop;
    rv_instr_t      head_instr;
    decoded_instr_t head_decoded;
    logic [1:0]     head_use_rs;

    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = !empty && (!out_valid_q || bus.out_ready);
    assign head_instr = instr_mem_q[rd_ptr_q[AW-1:0]];

    rv32_decoder_ext #(
        .ENABLE_M     (ENABLE_M),
        .ENABLE_ZICSR (ENABLE_ZICSR)
    ) u_decoder (
        .instr   (head_instr),
        .decoded (head_decoded),
        .use_rs  (head_use_rs)
    );

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        out_decoded_d = out_decoded_q;
        out_use_rs_d  = out_use_rs_q;

        if (push) begin
            instr_mem_d[wr_ptr_q[AW-1:0]] = bus.in_instr;
            pc_mem_d[wr_ptr_q[AW-1:0]]    = bus.in_pc;
            wr_ptr_d                      = wr_ptr_q + ptr_t'(1);
        end

        if (pop) begin
            rd_ptr_d      = rd_ptr_q + ptr_t'(1);
            out_valid_d   = 1'b1;
            out_pc_d      = pc_mem_q[rd_ptr_q[AW-1:0]];
            out_instr_d   = head_instr;
            out_decoded_d = head_decoded;
            out_use_rs_d  = head_use_rs;
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end

        // Flush overrides any push/pop computed above; payload memory is left as-is
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            out_valid_d   = 1'b0;
            out_pc_d      = '0;
            out_instr_d   = '0;
            out_decoded_d = create_nop_ctrl();
            out_use_rs_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            out_decoded_q <= create_nop_ctrl();
            out_use_rs_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            out_decoded_q <= out_decoded_d;
            out_use_rs_q  <= out_use_rs_d;
        end
    end

    assign bus.in_ready    = !full && !flush;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_decoded = out_decoded_q;
    assign bus.out_use_rs  = out_use_rs_q;
    assign count           = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_rv32_decode_buffer.sv
// tb/tb_rv32_decode_buffer.sv - directed bench for rv32_decode_buffer, full and reduced-ISA instances
module tb_rv32_decode_buffer;
    import rv32_types::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [1:0] count0;
    logic [1:0] count1;
    int         n_cmp = 0;
    int         n_err = 0;

    rv32_decode_buffer_if bus0 ();
    rv32_decode_buffer_if bus1 ();

    rv32_decode_buffer #(.DEPTH(2), .ENABLE_M(1'b1), .ENABLE_ZICSR(1'b1)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus0),
        .count (count0)
    );

    rv32_decode_buffer #(.DEPTH(2), .ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1),
        .count (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus0.in_valid = v; bus0.in_instr = instr; bus0.in_pc = pc;
        bus1.in_valid = v; bus1.in_instr = instr; bus1.in_pc = pc;
    endtask

    task automatic set_ready(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        drive(1'b1, instr, pc);
        chk("push_rdy", 32'(bus0.in_ready), 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0);
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        set_ready(1'b1);
        push(instr, pc);
        step();
        chk("issue_vld", 32'(bus0.out_valid), 32'd1);
        chk("issue_pc", bus0.out_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        set_ready(1'b0);
        step();
        step();
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_valid", 32'(bus0.out_valid), 32'd0);
        chk("rst_use_rs", 32'(bus0.out_use_rs), 32'd0);
        chk("rst_pc", bus0.out_pc, 32'h0);
        chk("rst_instr", bus0.out_instr, 32'h0);
        chk("rst_dec", 32'(bus0.out_decoded), 32'(create_nop_ctrl()));
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(bus0.in_ready), 32'd1);

        // addi x1,x0,5: one cycle from acceptance to out_valid
        set_ready(1'b1);
        push(32'h00500093, 32'h100);
        chk("t1_nobypass", 32'(bus0.out_valid), 32'd0);
        chk("t1_count_in", 32'(count0), 32'd1);
        step();
        chk("t1_valid", 32'(bus0.out_valid), 32'd1);
        chk("t1_pc", bus0.out_pc, 32'h100);
        chk("t1_instr", bus0.out_instr, 32'h00500093);
        chk("t1_wb", 32'(bus0.out_decoded.register_wb), 32'd1);
        chk("t1_use_rs", 32'(bus0.out_use_rs), 32'd1);
        chk("t1_count", 32'(count0), 32'd0);
        step();
        chk("t1_drained", 32'(bus0.out_valid), 32'd0);

        // Back-pressure: DEPTH in the FIFO plus one in the output stage
        set_ready(1'b0);
        for (int i = 0; i < 3; i++) begin
            push(((i + 1) << 20) | ((i + 1) << 7) | 32'h13, 32'h200 + 4 * i);
        end
        chk("t2_full_rdy", 32'(bus0.in_ready), 32'd0);
        chk("t2_full_cnt", 32'(count0), 32'd2);
        chk("t2_full_vld", 32'(bus0.out_valid), 32'd1);
        chk("t2_full_pc", bus0.out_pc, 32'h200);
        drive(1'b1, 32'h00400213, 32'h20C);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_hold_pc", bus0.out_pc, 32'h200);
            chk("t2_hold_instr", bus0.out_instr, 32'h00100093);
            chk("t2_hold_cnt", 32'(count0), 32'd2);
            chk("t2_hold_rdy", 32'(bus0.in_ready), 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0);
        set_ready(1'b1);
        for (int i = 1; i < 3; i++) begin
            step();
            chk("t2_drain_vld", 32'(bus0.out_valid), 32'd1);
            chk("t2_drain_pc", bus0.out_pc, 32'h200 + 4 * i);
            chk("t2_drain_cnt", 32'(count0), 32'(2 - i));
        end
        step();
        chk("t2_empty", 32'(bus0.out_valid), 32'd0);

        // mul x0,x1,x2: M extension on vs off
        issue(32'h02208033, 32'h300);
        chk("mul_unit", 32'(bus0.out_decoded.unit), 32'(UNIT_MULDIV));
        chk("mul_op", 32'(bus0.out_decoded.muldiv_op), 32'(MD_MUL));
        chk("mul_wb", 32'(bus0.out_decoded.register_wb), 32'd0);
        chk("mul_use_rs", 32'(bus0.out_use_rs), 32'd3);
        chk("mul_inv", 32'(bus0.out_decoded.invalid), 32'd0);
        chk("mul_noM_inv", 32'(bus1.out_decoded.invalid), 32'd1);
        chk("mul_noM_use", 32'(bus1.out_use_rs), 32'd0);

        // funct7 / funct3 legality
        issue(32'h4020D0B3, 32'h304);
        chk("sra_inv", 32'(bus0.out_decoded.invalid), 32'd0);
        chk("sra_op", 32'(bus0.out_decoded.alu_op), 32'(ALU_SRA));
        chk("sra_wb", 32'(bus0.out_decoded.register_wb), 32'd1);
        issue(32'h4020C0B3, 32'h308);
        chk("r100_inv", 32'(bus0.out_decoded.invalid), 32'd1);
        chk("r100_wb", 32'(bus0.out_decoded.register_wb), 32'd0);
        chk("r100_use", 32'(bus0.out_use_rs), 32'd0);
        chk("r100_mem", 32'(bus0.out_decoded.mem_op), 32'(MEM_NOP));
        issue(32'h0000B083, 32'h30C);
        chk("ld011_inv", 32'(bus0.out_decoded.invalid), 32'd1);
        issue(32'h0000A083, 32'h310);
        chk("lw_inv", 32'(bus0.out_decoded.invalid), 32'd0);
        chk("lw_mem", 32'(bus0.out_decoded.mem_op), 32'h2);
        chk("lw_wbsrc", 32'(bus0.out_decoded.wb_result_src), 32'(WB_MEM));
        chk("lw_use", 32'(bus0.out_use_rs), 32'd1);
        issue(32'h0020B023, 32'h314);
        chk("sd_inv", 32'(bus0.out_decoded.invalid), 32'd1);
        issue(32'h40109093, 32'h318);
        chk("slli_f7_inv", 32'(bus0.out_decoded.invalid), 32'd1);

        // Flush with two buffered and an offered instruction in the same cycle
        step();
        chk("t5_pre_empty", 32'(bus0.out_valid), 32'd0);
        set_ready(1'b0);
        push(32'h00100093, 32'h500);
        push(32'h00200113, 32'h504);
        push(32'h00300193, 32'h508);
        chk("t5_cnt2", 32'(count0), 32'd2);
        chk("t5_vld", 32'(bus0.out_valid), 32'd1);
        flush = 1'b1;
        drive(1'b1, 32'h00400213, 32'h50C);
        #1;
        chk("t5_flush_rdy", 32'(bus0.in_ready), 32'd0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("t5_cnt0", 32'(count0), 32'd0);
        chk("t5_vld0", 32'(bus0.out_valid), 32'd0);
        chk("t5_dec_nop", 32'(bus0.out_decoded), 32'(create_nop_ctrl()));
        set_ready(1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_ghost", 32'(bus0.out_valid), 32'd0);
            chk("t5_no_ghost_cnt", 32'(count0), 32'd0);
        end

        // Zicsr and SYSTEM
        issue(32'h34001073, 32'h600);
        chk("csr_unit", 32'(bus0.out_decoded.unit), 32'(UNIT_CSR));
        chk("csr_op", 32'(bus0.out_decoded.csr_op), 32'(CSR_RW));
        chk("csr_use", 32'(bus0.out_use_rs), 32'd1);
        chk("csr_wb", 32'(bus0.out_decoded.register_wb), 32'd0);
        chk("csr_wbsrc", 32'(bus0.out_decoded.wb_result_src), 32'(WB_CSR));
        chk("csr_noZ_inv", 32'(bus1.out_decoded.invalid), 32'd1);
        issue(32'h00100073, 32'h604);
        chk("ebreak_sys", 32'(bus0.out_decoded.sys_op), 32'(SYS_EBREAK));
        chk("ebreak_inv", 32'(bus0.out_decoded.invalid), 32'd0);
        chk("ebreak_wb", 32'(bus0.out_decoded.register_wb), 32'd0);
        issue(32'h00000073, 32'h608);
        chk("ecall_sys", 32'(bus0.out_decoded.sys_op), 32'(SYS_ECALL));
        chk("ecall_noZ_sys", 32'(bus1.out_decoded.sys_op), 32'(SYS_ECALL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
